// File: rtl/swc_alloc_pkg.sv
// Shared types for the swcore page-allocator arbiter: FSM states, op codes and
// the per-port op priority encoder.
package swc_alloc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } t_arb_state;

  typedef enum logic [1:0] {
    OP_ALLOC,
    OP_FREE,
    OP_SET_UCNT
  } t_alloc_op;

  // free > set_ucnt > alloc; the caller only asks when at least one is set
  function automatic t_alloc_op f_op_select(input logic alloc,
                                            input logic free,
                                            input logic set_ucnt);
    t_alloc_op op;
    if (free)
      op = OP_FREE;
    else if (set_ucnt)
      op = OP_SET_UCNT;
    else if (alloc)
      op = OP_ALLOC;
    else
      op = OP_ALLOC;
    return op;
  endfunction

endpackage

// File: rtl/swc_alloc_arbiter_if.sv
// Request/response and allocator-side bundle of swc_alloc_arbiter.
// SWC_ALLOC_USAGE_EN adds the per-port usage_o / usage_err_o outputs.
interface swc_alloc_arbiter_if #(
  parameter int g_num_ports   = 11,
  parameter int g_page_addr_w = 10,
  parameter int g_usecount_w  = 4
);

  logic [g_num_ports-1:0]                req_alloc_i;
  logic [g_num_ports-1:0]                req_free_i;
  logic [g_num_ports-1:0]                req_set_ucnt_i;
  logic [g_num_ports*g_page_addr_w-1:0]  req_pgaddr_i;
  logic [g_num_ports*g_usecount_w-1:0]   req_usecnt_i;

  logic [g_num_ports-1:0]                rsp_done_o;
  logic                                  rsp_nomem_o;
  logic [g_page_addr_w-1:0]              rsp_pgaddr_o;

  logic                                  mpm_alloc_o;
  logic                                  mpm_free_o;
  logic                                  mpm_set_ucnt_o;
  logic [g_page_addr_w-1:0]              mpm_pgaddr_o;
  logic [g_usecount_w-1:0]               mpm_usecnt_o;
  logic                                  mpm_idle_i;
  logic                                  mpm_done_i;
  logic [g_page_addr_w-1:0]              mpm_pgaddr_i;
  logic                                  mpm_nomem_i;

`ifdef SWC_ALLOC_USAGE_EN
  logic [g_num_ports*(g_page_addr_w+1)-1:0] usage_o;
  logic [g_num_ports-1:0]                   usage_err_o;
`endif

  // arbiter side
  modport master (
    input  req_alloc_i, req_free_i, req_set_ucnt_i, req_pgaddr_i, req_usecnt_i,
    output rsp_done_o, rsp_nomem_o, rsp_pgaddr_o,
    output mpm_alloc_o, mpm_free_o, mpm_set_ucnt_o, mpm_pgaddr_o, mpm_usecnt_o,
    input  mpm_idle_i, mpm_done_i, mpm_pgaddr_i, mpm_nomem_i
`ifdef SWC_ALLOC_USAGE_EN
    , output usage_o, usage_err_o
`endif
  );

  // requesters + allocator side
  modport slave (
    output req_alloc_i, req_free_i, req_set_ucnt_i, req_pgaddr_i, req_usecnt_i,
    input  rsp_done_o, rsp_nomem_o, rsp_pgaddr_o,
    input  mpm_alloc_o, mpm_free_o, mpm_set_ucnt_o, mpm_pgaddr_o, mpm_usecnt_o,
    output mpm_idle_i, mpm_done_i, mpm_pgaddr_i, mpm_nomem_i
`ifdef SWC_ALLOC_USAGE_EN
    , input usage_o, usage_err_o
`endif
  );

endinterface

// File: rtl/swc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping g_width-1 -> 0.
module swc_rr_arbiter #(
  parameter  int g_width = 4,
  localparam int IDX_W   = (g_width > 1) ? $clog2(g_width) : 1
) (
  input  logic [g_width-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [g_width-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_vld_o
);

  logic [2*g_width-1:0] req_dbl;
  logic [g_width-1:0]   req_rot;

  // rotate so that bit 0 is the port at the pointer
  assign req_dbl = {req_i, req_i};
  assign req_rot = g_width'(req_dbl >> ptr_i);

  always_comb begin
    int unsigned pos;
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    pos         = 0;
    for (int unsigned i = 0; i < g_width; i++) begin
      if (!grant_vld_o && req_rot[i]) begin
        grant_vld_o = 1'b1;
        pos         = int'(ptr_i) + i;
        if (pos >= g_width)
          pos = pos - g_width;
        grant_idx_o = IDX_W'(pos);
      end
    end
    grant_o = '0;
    if (grant_vld_o)
      grant_o = g_width'(1) << grant_idx_o;
  end

endmodule

// File: rtl/swc_alloc_arbiter.sv
// Round-robin sharing of the swcore page allocator between g_num_ports requesters.
// Optional per-port page usage accounting under SWC_ALLOC_USAGE_EN.
module swc_alloc_arbiter
  import swc_alloc_pkg::*;
#(
  parameter int g_num_ports   = 11,
  parameter int g_page_addr_w = 10,
  parameter int g_usecount_w  = 4
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  swc_alloc_arbiter_if.master  bus
);

  localparam int IDX_W = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;

  t_arb_state             state;
  t_alloc_op              op_q;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       gnt_idx_q;
  logic [g_num_ports-1:0] gnt_oh_q;

  logic [g_num_ports-1:0]   alloc_ok;
  logic [g_num_ports-1:0]   any_req;
  logic [g_num_ports-1:0]   grant_oh;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_vld;
  t_alloc_op                sel_op;
  logic [g_page_addr_w-1:0] sel_pgaddr;
  logic [g_usecount_w-1:0]  sel_usecnt;

  // allocs are invisible to arbitration while the allocator is out of pages
  assign alloc_ok = bus.req_alloc_i & {g_num_ports{~bus.mpm_nomem_i}};
  assign any_req  = alloc_ok | bus.req_free_i | bus.req_set_ucnt_i;

  swc_rr_arbiter #(
    .g_width (g_num_ports)
  ) u_rr_arbiter (
    .req_i       (any_req),
    .ptr_i       (rr_ptr),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign sel_op     = f_op_select(alloc_ok[grant_idx], bus.req_free_i[grant_idx],
                                  bus.req_set_ucnt_i[grant_idx]);
  assign sel_pgaddr = bus.req_pgaddr_i[grant_idx*g_page_addr_w +: g_page_addr_w];
  assign sel_usecnt = bus.req_usecnt_i[grant_idx*g_usecount_w +: g_usecount_w];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state              <= IDLE;
      op_q               <= OP_ALLOC;
      rr_ptr             <= '0;
      gnt_idx_q          <= '0;
      gnt_oh_q           <= '0;
      bus.rsp_done_o     <= '0;
      bus.rsp_nomem_o    <= 1'b0;
      bus.rsp_pgaddr_o   <= '0;
      bus.mpm_alloc_o    <= 1'b0;
      bus.mpm_free_o     <= 1'b0;
      bus.mpm_set_ucnt_o <= 1'b0;
      bus.mpm_pgaddr_o   <= '0;
      bus.mpm_usecnt_o   <= '0;
    end else begin
      bus.rsp_done_o     <= '0;
      bus.mpm_alloc_o    <= 1'b0;
      bus.mpm_free_o     <= 1'b0;
      bus.mpm_set_ucnt_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld && bus.mpm_idle_i) begin
            gnt_idx_q        <= grant_idx;
            gnt_oh_q         <= grant_oh;
            op_q             <= sel_op;
            bus.mpm_pgaddr_o <= sel_pgaddr;
            bus.mpm_usecnt_o <= sel_usecnt;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          case (op_q)
            OP_FREE:     bus.mpm_free_o     <= 1'b1;
            OP_SET_UCNT: bus.mpm_set_ucnt_o <= 1'b1;
            default:     bus.mpm_alloc_o    <= 1'b1;
          endcase
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mpm_done_i) begin
            bus.rsp_done_o <= gnt_oh_q;
            if (op_q == OP_ALLOC) begin
              bus.rsp_pgaddr_o <= bus.mpm_pgaddr_i;
              bus.rsp_nomem_o  <= bus.mpm_nomem_i;
            end else begin
              bus.rsp_nomem_o  <= 1'b0;
            end
            rr_ptr <= (gnt_idx_q == IDX_W'(g_num_ports - 1)) ? '0 : gnt_idx_q + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SWC_ALLOC_USAGE_EN
  localparam int CNT_W = g_page_addr_w + 1;

  logic [CNT_W-1:0]       usage_q [g_num_ports];
  logic [g_num_ports-1:0] usage_err_q;
  logic                   done_evt;

  assign done_evt = (state == WAIT) && bus.mpm_done_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned p = 0; p < g_num_ports; p++)
        usage_q[p] <= '0;
      usage_err_q <= '0;
    end else if (done_evt) begin
      for (int unsigned p = 0; p < g_num_ports; p++) begin
        if (gnt_oh_q[p]) begin
          if (op_q == OP_ALLOC) begin
            if (!bus.mpm_nomem_i && usage_q[p] != {1'b1, {g_page_addr_w{1'b0}}})
              usage_q[p] <= usage_q[p] + 1'b1;
          end else if (op_q == OP_FREE) begin
            // freeing with nothing held is a requester bug; flag it, keep count at 0
            if (usage_q[p] == '0)
              usage_err_q[p] <= 1'b1;
            else
              usage_q[p] <= usage_q[p] - 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < g_num_ports; g++) begin : g_usage
    assign bus.usage_o[g*CNT_W +: CNT_W] = usage_q[g];
  end
  assign bus.usage_err_o = usage_err_q;
`endif

endmodule
